// File: rtl/host_bfm_types_pkg.sv
// Shared host BFM types: packet tag, tag-pool FSM states and tag-space size.
package host_bfm_types_pkg;

   localparam int unsigned PKT_TAG_W = 10;
   localparam int unsigned MAX_TAGS  = 2**PKT_TAG_W;

   typedef logic [PKT_TAG_W-1:0] packet_tag_t;

   typedef enum logic {
      TP_INIT  = 1'b0,
      TP_READY = 1'b1
   } tag_pool_state_e;

endpackage

// File: rtl/host_bfm_tag_fifo.sv
// Circular free-list FIFO: async head read, sync write, wrapping pointers and occupancy count.
module host_bfm_tag_fifo
   import host_bfm_types_pkg::*;
#(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned W     = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [W:0]   count
);

   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] rd_ptr_q;
   logic [W-1:0] wr_ptr_q;
   logic [W:0]   count_q;

   // Storage write; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= push_data;
   end

   // Pointer and occupancy tracking, pointers wrap at DEPTH (not necessarily a power of two).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= (wr_ptr_q == W'(DEPTH-1)) ? '0 : wr_ptr_q + W'(1);
         if (pop)  rd_ptr_q <= (rd_ptr_q == W'(DEPTH-1)) ? '0 : rd_ptr_q + W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (W+1)'(1);
            2'b01:   count_q <= count_q - (W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign head  = mem[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/host_bfm_tag_pool.sv
// Tag allocator: hands out unique tags from a free list and reclaims them on completion.
module host_bfm_tag_pool
   import host_bfm_types_pkg::*;
#(
   parameter int unsigned NUM_TAGS = 1024,
   parameter int unsigned TAG_W    = 10
) (
   input  logic             clk,
   input  logic             rst,
   output logic             init_done,
   output logic             alloc_valid,
   input  logic             alloc_ready,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             free_valid,
   input  logic [TAG_W-1:0] free_tag,
   output logic [TAG_W:0]   outstanding,
   output logic             err_double_free,
   output logic             err_range
);

   tag_pool_state_e     state_q, state_d;
   logic [TAG_W-1:0]    init_cnt_q, init_cnt_d;
   logic [MAX_TAGS-1:0] bitmap_q, bitmap_d;
   logic [TAG_W:0]      outstanding_q, outstanding_d;
   logic                init_done_q, err_dbl_q, err_rng_q;

   logic                push;
   logic [TAG_W-1:0]    push_data;
   logic [TAG_W-1:0]    head;
   logic [TAG_W:0]      fifo_count;
   logic                alloc_fire, free_in_range, free_ok, free_dbl;

   host_bfm_tag_fifo #(.DEPTH(NUM_TAGS), .W(TAG_W)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (alloc_fire),
      .head      (head),
      .count     (fifo_count)
   );

   // Free/alloc qualification; bitmap is sampled before this cycle's allocation updates it.
   always_comb begin
      free_in_range = ({1'b0, free_tag} < (TAG_W+1)'(NUM_TAGS));
      free_ok       = free_valid && free_in_range && bitmap_q[free_tag] && (state_q == TP_READY);
      free_dbl      = free_valid && free_in_range && !free_ok;
      alloc_valid   = (state_q == TP_READY) && (fifo_count != '0);
      alloc_fire    = alloc_valid && alloc_ready;
      alloc_tag     = head;
   end

   // Next state: INIT fills the free list with 0..NUM_TAGS-1, READY pushes accepted frees.
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      push       = 1'b0;
      push_data  = free_tag;
      if (state_q == TP_INIT) begin
         push      = 1'b1;
         push_data = init_cnt_q;
         if (init_cnt_q == TAG_W'(NUM_TAGS-1)) begin
            state_d    = TP_READY;
            init_cnt_d = '0;
         end else begin
            init_cnt_d = init_cnt_q + TAG_W'(1);
         end
      end else begin
         push = free_ok;
      end
   end

   // In-use bitmap and outstanding count updates.
   always_comb begin
      bitmap_d = bitmap_q;
      if (alloc_fire) bitmap_d[head]     = 1'b1;
      if (free_ok)    bitmap_d[free_tag] = 1'b0;
      case ({alloc_fire, free_ok})
         2'b10:   outstanding_d = outstanding_q + (TAG_W+1)'(1);
         2'b01:   outstanding_d = outstanding_q - (TAG_W+1)'(1);
         default: outstanding_d = outstanding_q;
      endcase
   end

   // State register and registered status/error outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= TP_INIT;
         init_cnt_q    <= '0;
         bitmap_q      <= '0;
         outstanding_q <= '0;
         init_done_q   <= 1'b0;
         err_dbl_q     <= 1'b0;
         err_rng_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         init_cnt_q    <= init_cnt_d;
         bitmap_q      <= bitmap_d;
         outstanding_q <= outstanding_d;
         init_done_q   <= (state_d == TP_READY);
         err_dbl_q     <= free_dbl;
         err_rng_q     <= free_valid && !free_in_range;
      end
   end

   assign init_done       = init_done_q;
   assign outstanding     = outstanding_q;
   assign err_double_free = err_dbl_q;
   assign err_range       = err_rng_q;

endmodule

// File: tb/tb_host_bfm_tag_pool.sv
// Scoreboard bench for the tag pool: a free-list model predicts every allocated tag.
module tb_host_bfm_tag_pool;

   logic       clk = 1'b0;
   logic       rst;

   logic       init_done, alloc_valid, alloc_ready, free_valid;
   logic [9:0] alloc_tag, free_tag;
   logic [10:0] outstanding;
   logic       err_double_free, err_range;

   logic       b_init_done, b_alloc_valid, b_alloc_ready, b_free_valid;
   logic [9:0] b_alloc_tag, b_free_tag;
   logic [10:0] b_outstanding;
   logic       b_err_double_free, b_err_range;

   int checks = 0;
   int errors = 0;

   int fl[$];
   int sb[$];
   bit inuse[1024];
   int m_out;

   always #5 clk = ~clk;

   host_bfm_tag_pool u_dut (
      .clk(clk), .rst(rst), .init_done(init_done),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .free_valid(free_valid), .free_tag(free_tag), .outstanding(outstanding),
      .err_double_free(err_double_free), .err_range(err_range)
   );

   host_bfm_tag_pool #(.NUM_TAGS(512), .TAG_W(10)) u_dut_512 (
      .clk(clk), .rst(rst), .init_done(b_init_done),
      .alloc_valid(b_alloc_valid), .alloc_ready(b_alloc_ready), .alloc_tag(b_alloc_tag),
      .free_valid(b_free_valid), .free_tag(b_free_tag), .outstanding(b_outstanding),
      .err_double_free(b_err_double_free), .err_range(b_err_range)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      fl.delete();
      sb.delete();
      for (int i = 0; i < 1024; i++) begin
         fl.push_back(i);
         inuse[i] = 1'b0;
      end
      m_out = 0;
   endtask

   // One cycle on the 1024-tag pool: drive, predict, compare head before the edge, status after.
   task automatic step(input bit a, input bit fv, input int ft);
      bit exp_av, ok, dbl;
      int t, exp_tag;
      @(negedge clk);
      alloc_ready = a;
      free_valid  = fv;
      free_tag    = 10'(ft);
      exp_av = (fl.size() != 0);
      ok     = fv && inuse[ft];
      dbl    = fv && !inuse[ft];
      if (a && exp_av) begin
         t = fl.pop_front();
         sb.push_back(t);
         inuse[t] = 1'b1;
         m_out++;
      end
      if (ok) begin
         inuse[ft] = 1'b0;
         fl.push_back(ft);
         m_out--;
      end
      #1;
      check("alloc_valid", 32'(alloc_valid), 32'(exp_av));
      if (alloc_valid && alloc_ready) begin
         exp_tag = (sb.size() != 0) ? sb.pop_front() : -1;
         check("alloc_tag", 32'(alloc_tag), 32'(exp_tag));
      end
      @(posedge clk);
      #1;
      check("outstanding", 32'(outstanding), 32'(m_out));
      check("err_double_free", 32'(err_double_free), 32'(dbl));
      check("err_range", 32'(err_range), 32'(1'b0));
      alloc_ready = 1'b0;
      free_valid  = 1'b0;
   endtask

   // One free on the 512-tag pool, checking the error pulse and its clearing.
   task automatic bfree(input int ft, input bit exp_rng, input bit exp_dbl, input int exp_out);
      @(negedge clk);
      b_free_valid = 1'b1;
      b_free_tag   = 10'(ft);
      @(posedge clk);
      #1;
      b_free_valid = 1'b0;
      check("b_err_range", 32'(b_err_range), 32'(exp_rng));
      check("b_err_double_free", 32'(b_err_double_free), 32'(exp_dbl));
      check("b_outstanding", 32'(b_outstanding), 32'(exp_out));
      @(posedge clk);
      #1;
      check("b_err_range_clear", 32'(b_err_range), 32'(1'b0));
      check("b_err_double_clear", 32'(b_err_double_free), 32'(1'b0));
   endtask

   initial begin
      int waited;
      rst = 1'b1;
      alloc_ready = 1'b0; free_valid = 1'b0; free_tag = '0;
      b_alloc_ready = 1'b0; b_free_valid = 1'b0; b_free_tag = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_init_done", 32'(init_done), 32'(1'b0));
      check("rst_alloc_valid", 32'(alloc_valid), 32'(1'b0));
      check("rst_outstanding", 32'(outstanding), 32'(0));
      check("rst_err", 32'({err_double_free, err_range}), 32'(0));

      // init_done timing for both pool sizes
      @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i <= 1024; i++) begin
         @(posedge clk);
         #1;
         if (i == 511)  check("b_init_early", 32'(b_init_done), 32'(1'b0));
         if (i == 512)  check("b_init_done", 32'(b_init_done), 32'(1'b1));
         if (i == 1023) check("init_early", 32'(init_done), 32'(1'b0));
         if (i == 1023) check("init_alloc_valid", 32'(alloc_valid), 32'(1'b0));
         if (i == 1024) check("init_done", 32'(init_done), 32'(1'b1));
      end
      check("ready_alloc_tag", 32'(alloc_tag), 32'(0));
      check("ready_outstanding", 32'(outstanding), 32'(0));

      // range / double-free errors on the 512-tag pool
      bfree(1023, 1'b1, 1'b0, 0);
      bfree(600,  1'b1, 1'b0, 0);
      bfree(511,  1'b0, 1'b1, 0);
      @(negedge clk);
      b_alloc_ready = 1'b1;
      #1;
      check("b_alloc_tag", 32'(b_alloc_tag), 32'(0));
      @(posedge clk);
      #1;
      b_alloc_ready = 1'b0;
      check("b_outstanding_alloc", 32'(b_outstanding), 32'(1));
      bfree(0, 1'b0, 1'b0, 0);

      // first allocations, a free, a double free, then drain everything
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      step(0, 1, 1);
      step(0, 1, 7);
      waited = 0;
      while (fl.size() != 0 && waited < 2000) begin
         step(1, 0, 0);
         waited++;
      end
      step(1, 0, 0);

      // refill from empty with tag 5
      step(0, 1, 5);
      check("refill_tag", 32'(alloc_tag), 32'(5));
      step(1, 0, 0);
      step(1, 0, 0);

      // simultaneous alloc of head 10 and free of 3, then alloc+free of the same tag
      step(0, 1, 10);
      step(0, 1, 20);
      step(1, 1, 3);
      step(1, 0, 0);
      step(1, 0, 0);
      step(0, 1, 30);
      step(1, 1, 30);
      step(0, 1, 30);
      step(1, 0, 0);

      // bring outstanding down to 100, then reset mid-operation
      for (int t = 100; t < 1024; t++) step(0, 1, t);
      check("pre_reset_outstanding", 32'(outstanding), 32'(100));
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_outstanding", 32'(outstanding), 32'(0));
      check("midrst_alloc_valid", 32'(alloc_valid), 32'(1'b0));
      check("midrst_init_done", 32'(init_done), 32'(1'b0));
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      waited = 0;
      while (init_done !== 1'b1 && waited < 2000) begin
         @(posedge clk);
         #1;
         waited++;
      end
      check("reinit_cycles", 32'(waited), 32'(1024));
      step(1, 0, 0);
      step(1, 0, 0);
      check("sb_drained", 32'(sb.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
